// File: rtl/stream_demux_1to2_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2_if
// Description : Producer-side and two consumer-side valid/ready handshakes
//               plus per-channel occupancy for the buffered 1-to-2 demux.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_1to2_if #(
    parameter int NBITS = 32,
    parameter int DEPTH = 2
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    logic               Selector;
    logic               DEMUX_Valid;
    logic [NBITS-1:0]   DEMUX_Data;
    logic               DEMUX_Ready;

    logic               Out0_Valid;
    logic [NBITS-1:0]   Out0_Data;
    logic               Out0_Ready;

    logic               Out1_Valid;
    logic [NBITS-1:0]   Out1_Data;
    logic               Out1_Ready;

    logic [c_LVL_W-1:0] Level0;
    logic [c_LVL_W-1:0] Level1;

    // Demux side: accepts the producer stream and sources both channels.
    modport slave (
        input  Selector, DEMUX_Valid, DEMUX_Data, Out0_Ready, Out1_Ready,
        output DEMUX_Ready, Out0_Valid, Out0_Data, Out1_Valid, Out1_Data,
        output Level0, Level1
    );

    // Environment side: producer and both consumers.
    modport master (
        output Selector, DEMUX_Valid, DEMUX_Data, Out0_Ready, Out1_Ready,
        input  DEMUX_Ready, Out0_Valid, Out0_Data, Out1_Valid, Out1_Data,
        input  Level0, Level1
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2
// Description : Buffered 1-to-2 stream demultiplexer; each accepted word is
//               steered by Selector into a private per-channel FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1to2 #(
    parameter int NBITS = 32,
    parameter int DEPTH = 2     // power of two, >= 2
) (
    input wire                  clk,
    input wire                  reset,      // asynchronous, active-low
    stream_demux_1to2_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [NBITS-1:0]   r_mem    [2][DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr [2];
    logic [c_PTR_W-1:0] r_rd_ptr [2];
    logic [c_LVL_W-1:0] r_level  [2];

    logic [1:0] w_full;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_ready;

    assign w_out_ready = {bus.Out1_Ready, bus.Out0_Ready};

    // Ready depends only on the selected channel's fullness, so a pop on a
    // full channel frees the slot for the following edge, not this one.
    always_comb begin
        w_full = '0;
        w_push = '0;
        w_pop  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            w_full[ch] = (r_level[ch] == c_FULL_LVL);
            w_push[ch] = bus.DEMUX_Valid && !w_full[ch] && (bus.Selector == 1'(ch));
            w_pop[ch]  = (r_level[ch] != '0) && w_out_ready[ch];
        end
    end

    assign bus.DEMUX_Ready = !w_full[bus.Selector];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_wr_ptr[ch] <= '0;
                r_rd_ptr[ch] <= '0;
                r_level[ch]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[ch][i] <= '0;
                end
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (w_push[ch]) begin
                    r_mem[ch][r_wr_ptr[ch]] <= bus.DEMUX_Data;
                    r_wr_ptr[ch]            <= r_wr_ptr[ch] + 1'b1;
                end
                if (w_pop[ch]) begin
                    r_rd_ptr[ch] <= r_rd_ptr[ch] + 1'b1;
                end
                if (w_push[ch] && !w_pop[ch]) begin
                    r_level[ch] <= r_level[ch] + 1'b1;
                end else if (!w_push[ch] && w_pop[ch]) begin
                    r_level[ch] <= r_level[ch] - 1'b1;
                end
            end
        end
    end

    // Heads are read straight from storage: no input-to-output bypass.
    assign bus.Out0_Valid = (r_level[0] != '0);
    assign bus.Out1_Valid = (r_level[1] != '0);
    assign bus.Out0_Data  = r_mem[0][r_rd_ptr[0]];
    assign bus.Out1_Data  = r_mem[1][r_rd_ptr[1]];
    assign bus.Level0     = r_level[0];
    assign bus.Level1     = r_level[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Directed self-checking bench for stream_demux_1to2 (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;
    localparam int c_NBITS = 32;
    localparam int c_DEPTH = 2;

    logic clk;
    logic reset;

    int n_total = 0;
    int n_bad   = 0;

    stream_demux_1to2_if #(.NBITS(c_NBITS), .DEPTH(c_DEPTH)) bus ();

    stream_demux_1to2 #(.NBITS(c_NBITS), .DEPTH(c_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 2 time units after the active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic sel, input logic [31:0] data);
        bus.Selector    = sel;
        bus.DEMUX_Data  = data;
        bus.DEMUX_Valid = 1'b1;
        tick();
        bus.DEMUX_Valid = 1'b0;
    endtask

    // Pop monitor for the streaming phase; samples on the falling edge.
    logic        mon_en = 1'b0;
    int          pops   = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.Out0_Valid && bus.Out0_Ready) begin
                check("ch0_stream_data", bus.Out0_Data, (exp0.size() > 0) ? exp0.pop_front() : 32'hDEAD_0000);
                pops++;
            end
            if (bus.Out1_Valid && bus.Out1_Ready) begin
                check("ch1_stream_data", bus.Out1_Data, (exp1.size() > 0) ? exp1.pop_front() : 32'hDEAD_0001);
                pops++;
            end
        end
    end

    logic prod_done;

    initial begin
        reset           = 1'b0;
        bus.Selector    = 1'b0;
        bus.DEMUX_Valid = 1'b0;
        bus.DEMUX_Data  = '0;
        bus.Out0_Ready  = 1'b0;
        bus.Out1_Ready  = 1'b0;
        prod_done       = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        #1;
        check("rst_out0_valid", bus.Out0_Valid, 0);
        check("rst_out1_valid", bus.Out1_Valid, 0);
        check("rst_level0", bus.Level0, 0);
        check("rst_level1", bus.Level1, 0);
        check("rst_ready", bus.DEMUX_Ready, 1);
        check("rst_out0_data", bus.Out0_Data, 0);
        check("rst_out1_data", bus.Out1_Data, 0);

        // Single word to channel 0, consumers ready
        bus.Out0_Ready = 1'b1;
        bus.Out1_Ready = 1'b1;
        push_word(1'b0, 32'hAAAA_0001);
        #1;
        check("single_out0_valid", bus.Out0_Valid, 1);
        check("single_out0_data", bus.Out0_Data, 32'hAAAA_0001);
        check("single_out1_idle", bus.Out1_Valid, 0);
        check("single_level0", bus.Level0, 1);
        tick();
        #1;
        check("single_popped", bus.Out0_Valid, 0);

        // Fill channel 0, then route around it to channel 1
        bus.Out0_Ready = 1'b0;
        bus.Out1_Ready = 1'b0;
        push_word(1'b0, 32'h10);
        push_word(1'b0, 32'h11);
        bus.Selector    = 1'b0;
        bus.DEMUX_Data  = 32'h12;
        bus.DEMUX_Valid = 1'b1;
        #1;
        check("full_level0", bus.Level0, 2);
        check("full_ready_sel0", bus.DEMUX_Ready, 0);
        check("full_head0", bus.Out0_Data, 32'h10);
        bus.Selector   = 1'b1;
        bus.DEMUX_Data = 32'h20;
        #1;
        check("full_ready_sel1", bus.DEMUX_Ready, 1);
        tick();
        bus.DEMUX_Valid = 1'b0;
        bus.Out1_Ready  = 1'b1;
        #1;
        check("ch1_valid", bus.Out1_Valid, 1);
        check("ch1_data", bus.Out1_Data, 32'h20);
        check("ch0_head_stable", bus.Out0_Data, 32'h10);
        check("ch0_level_stable", bus.Level0, 2);
        tick();
        #1;
        check("ch1_drained", bus.Out1_Valid, 0);

        // Full channel popped while a push waits
        bus.Selector    = 1'b0;
        bus.DEMUX_Data  = 32'h12;
        bus.DEMUX_Valid = 1'b1;
        bus.Out0_Ready  = 1'b1;
        #1;
        check("fullpop_ready", bus.DEMUX_Ready, 0);
        tick();
        #1;
        check("fullpop_level0", bus.Level0, 1);
        check("fullpop_head", bus.Out0_Data, 32'h11);
        check("fullpop_ready_after", bus.DEMUX_Ready, 1);
        tick();
        bus.DEMUX_Valid = 1'b0;
        #1;
        check("pushpop_level0", bus.Level0, 1);
        check("pushpop_head", bus.Out0_Data, 32'h12);
        tick();
        #1;
        check("pushpop_drained", bus.Level0, 0);

        // Alternating stream under random backpressure
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp0.push_back(32'h100 + 32'(i));
            else            exp1.push_back(32'h100 + 32'(i));
        end
        pops   = 0;
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int  k;
                    logic acc;
                    k   = 0;
                    acc = 1'b0;
                    bus.Selector    = 1'(i % 2);
                    bus.DEMUX_Data  = 32'h100 + 32'(i);
                    bus.DEMUX_Valid = 1'b1;
                    while (!acc && k < 50) begin
                        @(negedge clk);
                        acc = bus.DEMUX_Ready;
                        tick();
                        k++;
                    end
                    if (!acc) check("stream_push_timeout", k, 0);
                end
                bus.DEMUX_Valid = 1'b0;
                prod_done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!prod_done && c < 400) begin
                    bus.Out0_Ready = 1'($urandom_range(0, 1));
                    bus.Out1_Ready = 1'($urandom_range(0, 1));
                    tick();
                    c++;
                end
            end
        join
        bus.Out0_Ready = 1'b1;
        bus.Out1_Ready = 1'b1;
        for (int k = 0; k < 20 && pops < 6; k++) tick();
        mon_en = 1'b0;
        check("stream_handshakes", pops, 6);
        check("stream_ch0_left", exp0.size(), 0);
        check("stream_ch1_left", exp1.size(), 0);
        tick();
        #1;
        check("stream_level0_end", bus.Level0, 0);
        check("stream_level1_end", bus.Level1, 0);

        // Asynchronous reset with buffered words
        bus.Out0_Ready = 1'b0;
        bus.Out1_Ready = 1'b0;
        push_word(1'b0, 32'h30);
        push_word(1'b0, 32'h31);
        push_word(1'b1, 32'h40);
        #1;
        check("prerst_level0", bus.Level0, 2);
        check("prerst_level1", bus.Level1, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out0_valid", bus.Out0_Valid, 0);
        check("arst_out1_valid", bus.Out1_Valid, 0);
        check("arst_level0", bus.Level0, 0);
        check("arst_level1", bus.Level1, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        #1;
        check("postrst_ready", bus.DEMUX_Ready, 1);
        check("postrst_out0_data", bus.Out0_Data, 0);
        check("postrst_out1_valid", bus.Out1_Valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
